game_sequencer: RTL and testbench

- Match controller for the ping-pong game datapath, running in the char_clock domain.
- Derives the game-tick enable from vsync frame edges and debounces the start key on those ticks.
- Sequences match phases (idle, serve countdown, rally, goal pause, game over) and owns the goal and hit scoring registers.
- Ball/racket datapath advances only on tick; it moves the ball only while play=1, reloads the serve position on ball_load, and reports goal_evt/hit_evt back.

---
 rtl/game_sequencer_pkg.sv | 26 ++
 rtl/game_sequencer_if.sv | 51 +++++
 rtl/game_sequencer_key_tick_sync.sv | 37 +++
 rtl/game_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_sequencer_pkg.sv
// game_pkg: shared definitions for the ping-pong match controller.
//   - state_e      : FSM state codes (IDLE=0 .. PAUSE=5), STATE_W bits wide
//   - GOALS_W      : width of the thermometer goal and hit registers
//   - HITS_MAX     : saturation value of the rally hit counter
//   - DEF_*        : default timing/match parameters for game_sequencer
package game_pkg;

  localparam int STATE_W = 3;
  localparam int GOALS_W = 8;
  localparam int HITS_MAX = 255;

  localparam int DEF_TICK_DIV = 3;
  localparam int DEF_SERVE_TICKS = 40;
  localparam int DEF_GOAL_PAUSE_TICKS = 60;
  localparam int DEF_MAX_GOALS = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    GOAL  = 3'd3,
    OVER  = 3'd4,
    PAUSE = 3'd5
  } state_e;

endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: signal bundle between the match controller and the
// ball/racket datapath plus the player keys.
//   master modport : the controller (game_sequencer)
//   slave modport  : the datapath / key side
// Signals: vsync, key_start (active-low), [key_pause (active-low) when
// GAME_SEQ_PAUSE_EN is defined], goal_evt, hit_evt in; tick, ball_load,
// play, state, goals, hits, game_over out of the controller.
//
// Protocol: there is no back-pressure. tick, ball_load, goal_evt and hit_evt
// are single-cycle pulses that the receiver must act on in the cycle they
// are high; play, state, goals, hits and game_over are levels that hold
// until the controller changes them.
interface game_sequencer_if;
  import game_pkg::*;

  logic               vsync;
  logic               key_start;
`ifdef GAME_SEQ_PAUSE_EN
  logic               key_pause;
`endif
  logic               goal_evt;
  logic               hit_evt;
  logic               tick;
  logic               ball_load;
  logic               play;
  logic [STATE_W-1:0] state;
  logic [GOALS_W-1:0] goals;
  logic [GOALS_W-1:0] hits;
  logic               game_over;

`ifdef GAME_SEQ_PAUSE_EN
  modport master (
    input  vsync, key_start, key_pause, goal_evt, hit_evt,
    output tick, ball_load, play, state, goals, hits, game_over
  );
  modport slave (
    output vsync, key_start, key_pause, goal_evt, hit_evt,
    input  tick, ball_load, play, state, goals, hits, game_over
  );
`else
  modport master (
    input  vsync, key_start, goal_evt, hit_evt,
    output tick, ball_load, play, state, goals, hits, game_over
  );
  modport slave (
    output vsync, key_start, goal_evt, hit_evt,
    input  tick, ball_load, play, state, goals, hits, game_over
  );
`endif

endinterface

// File: rtl/game_sequencer_key_tick_sync.sv
// key_tick_sync: brings an asynchronous active-low key into the clock domain
// with a two-flop synchronizer, samples the synchronized level only on game
// ticks, and emits a one-cycle press pulse on a released->pressed change
// between consecutive tick samples (a held key gives a single press).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (flops reset to 1 = released)
//   key_n_i    : raw active-low key
//   tick_i     : game tick enable
//   press_o    : press pulse, high only during a tick cycle
module key_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  input  logic tick_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic samp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      samp_q  <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      if (tick_i) samp_q <= sync2_q;
    end
  end

  // Current tick sample is sync2_q itself; samp_q holds the previous one.
  assign press_o = tick_i & ~sync2_q & samp_q;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: match controller for the ping-pong datapath (char_clock domain).
// Derives the game tick from vsync frame edges, debounces the start key on
// ticks, sequences IDLE/SERVE/PLAY/GOAL/OVER and owns the goal/hit scores.
// Optional macro GAME_SEQ_PAUSE_EN adds the key_pause input and PAUSE state.
// Ports:
//   char_clock : sole clock
//   reset      : asynchronous active-high reset
//   bus        : game_sequencer_if.master (vsync, keys, goal/hit events in;
//                tick, ball_load, play, state, goals, hits, game_over out)
module game_sequencer
  import game_pkg::*;
#(
  parameter int TICK_DIV         = DEF_TICK_DIV,
  parameter int SERVE_TICKS      = DEF_SERVE_TICKS,
  parameter int GOAL_PAUSE_TICKS = DEF_GOAL_PAUSE_TICKS,
  parameter int MAX_GOALS        = DEF_MAX_GOALS
) (
  input  logic              char_clock,
  input  logic              reset,
  game_sequencer_if.master  bus
);

  localparam int FRAME_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX    = (SERVE_TICKS > GOAL_PAUSE_TICKS) ? SERVE_TICKS : GOAL_PAUSE_TICKS;
  localparam int TIMER_W = $clog2(TMAX + 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(TICK_DIV - 1);
  localparam logic [TIMER_W-1:0] SERVE_T    = TIMER_W'(SERVE_TICKS);
  localparam logic [TIMER_W-1:0] GOAL_T     = TIMER_W'(GOAL_PAUSE_TICKS);
  localparam logic [GOALS_W-1:0] HITS_SAT   = GOALS_W'(HITS_MAX);

  // ---------------- frame edge and tick generation ----------------
  logic               vs_q;
  logic [FRAME_W-1:0] frame_cnt_q;
  logic               tick_q;
  logic               frame;

  assign frame = bus.vsync & ~vs_q;

  always_ff @(posedge char_clock or posedge reset) begin
    if (reset) begin
      vs_q        <= 1'b0;
      frame_cnt_q <= '0;
      tick_q      <= 1'b0;
    end else begin
      vs_q   <= bus.vsync;
      tick_q <= 1'b0;
      if (frame) begin
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_q <= '0;
          tick_q      <= 1'b1;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------- keys ----------------
  logic start_press;

  key_tick_sync u_start_sync (
    .clk     (char_clock),
    .rst     (reset),
    .key_n_i (bus.key_start),
    .tick_i  (tick_q),
    .press_o (start_press)
  );

`ifdef GAME_SEQ_PAUSE_EN
  logic pause_press;

  key_tick_sync u_pause_sync (
    .clk     (char_clock),
    .rst     (reset),
    .key_n_i (bus.key_pause),
    .tick_i  (tick_q),
    .press_o (pause_press)
  );
`endif

  // ---------------- match FSM ----------------
  state_e             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [GOALS_W-1:0] goals_q;
  logic [GOALS_W-1:0] hits_q;
  logic               play_q;
  logic               game_over_q;
  logic               ball_load_q;
  logic [GOALS_W-1:0] goals_d;

  // Thermometer: each goal shifts in another 1 from the LSB.
  assign goals_d = {goals_q[GOALS_W-2:0], 1'b1};

  always_ff @(posedge char_clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      goals_q     <= '0;
      hits_q      <= '0;
      play_q      <= 1'b0;
      game_over_q <= 1'b0;
      ball_load_q <= 1'b0;
    end else begin
      ball_load_q <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (start_press) begin
            state_q     <= SERVE;
            goals_q     <= '0;
            hits_q      <= '0;
            timer_q     <= SERVE_T;
            ball_load_q <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
        SERVE: begin
          if (tick_q) begin
            timer_q <= timer_q - 1'b1;
            if (timer_q == TIMER_W'(1)) begin
              state_q <= PLAY;
              play_q  <= 1'b1;
            end
          end
        end
        PLAY: begin
          // A goal wins over a simultaneous hit; the hit is dropped.
          if (bus.goal_evt) begin
            goals_q <= goals_d;
            play_q  <= 1'b0;
            if (goals_d[MAX_GOALS-1]) begin
              state_q     <= OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q <= GOAL;
              timer_q <= GOAL_T;
            end
          end else begin
            if (bus.hit_evt && hits_q != HITS_SAT) hits_q <= hits_q + 1'b1;
`ifdef GAME_SEQ_PAUSE_EN
            if (pause_press) begin
              state_q <= PAUSE;
              play_q  <= 1'b0;
            end
`endif
          end
        end
        GOAL: begin
          if (tick_q) begin
            timer_q <= timer_q - 1'b1;
            if (timer_q == TIMER_W'(1)) begin
              state_q     <= SERVE;
              timer_q     <= SERVE_T;
              ball_load_q <= 1'b1;
            end
          end
        end
`ifdef GAME_SEQ_PAUSE_EN
        PAUSE: begin
          if (pause_press) begin
            state_q <= PLAY;
            play_q  <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          play_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tick      = tick_q;
  assign bus.ball_load = ball_load_q;
  assign bus.play      = play_q;
  assign bus.state     = state_q;
  assign bus.goals     = goals_q;
  assign bus.hits      = hits_q;
  assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer with TICK_DIV=3, SERVE_TICKS=4,
// GOAL_PAUSE_TICKS=2, MAX_GOALS=3. Randomized frame lengths, hit counts and
// gaps; expected values come from the game rules (frames per tick, serve and
// pause lengths in ticks, thermometer goals, saturating hits).
module tb_game_sequencer;
  import game_pkg::*;

  localparam int TICK_DIV         = 3;
  localparam int SERVE_TICKS      = 4;
  localparam int GOAL_PAUSE_TICKS = 2;
  localparam int MAX_GOALS        = 3;

  // ---------------- clock / reset ----------------
  logic char_clock = 1'b0;
  logic reset      = 1'b1;
  always #5 char_clock = ~char_clock;

  game_sequencer_if bus ();

  game_sequencer #(
    .TICK_DIV         (TICK_DIV),
    .SERVE_TICKS      (SERVE_TICKS),
    .GOAL_PAUSE_TICKS (GOAL_PAUSE_TICKS),
    .MAX_GOALS        (MAX_GOALS)
  ) dut (
    .char_clock (char_clock),
    .reset      (reset),
    .bus        (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_no = 0;
  int tick_seen = 0;
  int bl_count = 0;
  logic bl_at_tick = 1'b0;
  logic [31:0] exp_q[$];   // expected tick cycle numbers

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rules.
  function automatic logic [7:0] exp_goals(input int n);
    int v;
    v = (1 << n) - 1;
    return v[7:0];
  endfunction

  function automatic logic [7:0] exp_hits(input int n);
    int v;
    v = (n > 255) ? 255 : n;
    return v[7:0];
  endfunction

  always @(posedge char_clock) cyc++;

  // Tick monitor: every tick must land on the cycle the frame model predicted.
  always @(negedge char_clock) begin : mon
    logic [31:0] want;
    if (!reset && bus.tick === 1'b1) begin
      tick_seen++;
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check("tick_cycle", cyc, want);
    end
    if (!reset && bus.ball_load === 1'b1) bl_count++;
  end

  // ---------------- driver tasks ----------------
  // One vsync pulse of random width; every TICK_DIV-th frame predicts a tick
  // one cycle after the edge-detect cycle.
  task automatic frame();
    int hi;
    int lo;
    hi = $urandom_range(1, 3);
    lo = $urandom_range(2, 4);
    @(negedge char_clock);
    bus.vsync = 1'b1;
    frame_no++;
    if (frame_no % TICK_DIV == 0) exp_q.push_back(cyc + 1);
    for (int i = 0; i < hi + lo; i++) begin
      @(negedge char_clock);
      if (i == 1) bl_at_tick = bus.ball_load;
      if (i == hi - 1) bus.vsync = 1'b0;
    end
    check("tick_missing", exp_q.size(), 0);
  endtask

  task automatic tick_step();
    repeat (TICK_DIV) frame();
  endtask

  task automatic pulse(input logic g, input logic h);
    @(negedge char_clock);
    bus.goal_evt = g;
    bus.hit_evt  = h;
    @(negedge char_clock);
    bus.goal_evt = 1'b0;
    bus.hit_evt  = 1'b0;
  endtask

  task automatic hits_n(input int n);
    for (int i = 0; i < n; i++) begin
      pulse(1'b0, 1'b1);
      repeat ($urandom_range(0, 1)) @(negedge char_clock);
    end
  endtask

  // ---------------- directed sequence ----------------
  int n1, n2, n3, m_hits, m_goals, bl0;

  initial begin
    bus.vsync     = 1'b0;
    bus.key_start = 1'b1;
`ifdef GAME_SEQ_PAUSE_EN
    bus.key_pause = 1'b1;
`endif
    bus.goal_evt  = 1'b0;
    bus.hit_evt   = 1'b0;
    repeat (3) @(negedge char_clock);

    check("rst_state", bus.state, 0);
    check("rst_tick", bus.tick, 0);
    check("rst_ball_load", bus.ball_load, 0);
    check("rst_play", bus.play, 0);
    check("rst_game_over", bus.game_over, 0);
    check("rst_goals", bus.goals, 0);
    check("rst_hits", bus.hits, 0);
    reset = 1'b0;

    // Nine frames give three ticks.
    repeat (9) frame();
    check("tick_count_9_frames", tick_seen, 3);
    check("idle_no_key", bus.state, 0);

    // Held start key: one press, serve lasts SERVE_TICKS ticks.
    bus.key_start = 1'b0;
    repeat (3) @(negedge char_clock);
    bl0 = bl_count;
    tick_step();
    check("start_state", bus.state, 1);
    check("start_ball_load", bl_at_tick, 1);
    check("start_play", bus.play, 0);
    for (int k = 1; k <= SERVE_TICKS; k++) begin
      tick_step();
      check("serve_state", bus.state, (k < SERVE_TICKS) ? 1 : 2);
      check("serve_play", bus.play, (k < SERVE_TICKS) ? 0 : 1);
    end
    for (int k = 0; k < 10 - 1 - SERVE_TICKS; k++) begin
      tick_step();
      check("held_key_state", bus.state, 2);
    end
    check("held_key_one_load", bl_count - bl0, 1);
    bus.key_start = 1'b1;

    // Rally 1: random hits, then goal together with a hit.
    m_goals = 0;
    n1 = $urandom_range(5, 40);
    hits_n(n1);
    m_hits = n1;
    check("hits_rally1", bus.hits, exp_hits(m_hits));
    pulse(1'b1, 1'b1);
    m_goals++;
    check("goal1_goals", bus.goals, exp_goals(m_goals));
    check("goal1_hit_dropped", bus.hits, exp_hits(m_hits));
    check("goal1_state", bus.state, 3);
    check("goal1_play", bus.play, 0);
    pulse(1'b1, 1'b1);
    check("goal_state_ignores_goal", bus.goals, exp_goals(m_goals));
    check("goal_state_ignores_hit", bus.hits, exp_hits(m_hits));
    bl0 = bl_count;
    for (int k = 1; k <= GOAL_PAUSE_TICKS; k++) begin
      tick_step();
      check("goal_pause_state", bus.state, (k < GOAL_PAUSE_TICKS) ? 3 : 1);
    end
    check("reserve_ball_load", bl_at_tick, 1);
    check("reserve_load_count", bl_count - bl0, 1);
    repeat (SERVE_TICKS) tick_step();
    check("rally2_state", bus.state, 2);

    // Rally 2: saturate hits, then second goal.
    n2 = 300 - n1 + $urandom_range(0, 20);
    hits_n(n2);
    m_hits = n1 + n2;
    check("hits_saturate", bus.hits, exp_hits(m_hits));
    pulse(1'b1, 1'b0);
    m_goals++;
    check("goal2_goals", bus.goals, exp_goals(m_goals));
    check("goal2_state", bus.state, 3);
    repeat (GOAL_PAUSE_TICKS + SERVE_TICKS) tick_step();
    check("rally3_state", bus.state, 2);

    // Final goal ends the match.
    pulse(1'b1, 1'b0);
    m_goals++;
    check("goal3_goals", bus.goals, exp_goals(m_goals));
    check("over_state", bus.state, 4);
    check("over_flag", bus.game_over, 1);
    check("over_play", bus.play, 0);
    pulse(1'b1, 1'b1);
    check("over_goals_hold", bus.goals, exp_goals(m_goals));
    check("over_hits_hold", bus.hits, exp_hits(m_hits));
    check("over_state_hold", bus.state, 4);

    // Restart from OVER.
    bus.key_start = 1'b0;
    repeat (3) @(negedge char_clock);
    bl0 = bl_count;
    tick_step();
    bus.key_start = 1'b1;
    m_goals = 0;
    m_hits  = 0;
    check("restart_state", bus.state, 1);
    check("restart_goals", bus.goals, exp_goals(m_goals));
    check("restart_hits", bus.hits, exp_hits(m_hits));
    check("restart_game_over", bus.game_over, 0);
    check("restart_load", bl_count - bl0, 1);
    repeat (SERVE_TICKS) tick_step();
    check("restart_play_state", bus.state, 2);
    n3 = $urandom_range(1, 20);
    hits_n(n3);
    m_hits = n3;
    check("hits_rally_new", bus.hits, exp_hits(m_hits));

`ifdef GAME_SEQ_PAUSE_EN
    bus.key_pause = 1'b0;
    repeat (3) @(negedge char_clock);
    tick_step();
    check("pause_state", bus.state, 5);
    check("pause_play", bus.play, 0);
    pulse(1'b1, 1'b1);
    check("pause_goals_ignored", bus.goals, exp_goals(m_goals));
    check("pause_hits_ignored", bus.hits, exp_hits(m_hits));
    check("pause_state_hold", bus.state, 5);
    bus.key_pause = 1'b1;
    tick_step();
    check("pause_release_state", bus.state, 5);
    bus.key_pause = 1'b0;
    repeat (3) @(negedge char_clock);
    tick_step();
    check("resume_state", bus.state, 2);
    check("resume_play", bus.play, 1);
    bus.key_pause = 1'b1;
    tick_step();
`endif

    // Asynchronous reset between clock edges, mid-PLAY.
    check("pre_reset_play", bus.play, 1);
    @(posedge char_clock);
    #2 reset = 1'b1;
    #1;
    check("areset_state", bus.state, 0);
    check("areset_tick", bus.tick, 0);
    check("areset_ball_load", bus.ball_load, 0);
    check("areset_play", bus.play, 0);
    check("areset_game_over", bus.game_over, 0);
    check("areset_goals", bus.goals, 0);
    check("areset_hits", bus.hits, 0);
    @(negedge char_clock);
    reset = 1'b0;
    frame_no = 0;
    repeat (3) @(negedge char_clock);
    check("post_reset_state", bus.state, 0);
    check("tick_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
